// File: rtl/audio_seq_pkg.sv
// Shared track codes, default sizing constants and the track priority rule
// for the audio track sequencer.
package audio_seq_pkg;

    localparam logic [2:0] TRK_SILENT = 3'd0;
    localparam logic [2:0] TRK_FULL   = 3'd1;
    localparam logic [2:0] TRK_LOW    = 3'd2;
    localparam logic [2:0] TRK_DANGER = 3'd3;
    localparam logic [2:0] TRK_WIN    = 3'd4;
    localparam logic [2:0] TRK_LOSS   = 3'd5;

    localparam int DEF_SAMPLE_DIV = 6250;
    localparam int DEF_LONG_LEN   = 64000;
    localparam int DEF_SHORT_LEN  = 32000;
    localparam int DEF_LOW_TH     = 12;
    localparam int DEF_DANGER_TH  = 8;

    // Priority: win beats loss beats the oxygen bands.
    function automatic logic [2:0] select_track(
        input logic       win,
        input logic       loss,
        input logic [6:0] sec,
        input logic [6:0] low_th,
        input logic [6:0] danger_th
    );
        logic [2:0] t;
        if (win)                   t = TRK_WIN;
        else if (loss)             t = TRK_LOSS;
        else if (sec >= low_th)    t = TRK_FULL;
        else if (sec >= danger_th) t = TRK_LOW;
        else                       t = TRK_DANGER;
        return t;
    endfunction

endpackage

// File: rtl/sample_tick_divider.sv
// Free-running divider producing a one-cycle sample-rate tick every
// SAMPLE_DIV clocks; the first tick comes SAMPLE_DIV cycles after reset.
module sample_tick_divider #(
    parameter int SAMPLE_DIV = 6250
) (
    input  logic CLOCK_50,
    input  logic resetn,
    output logic tick
);
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == CW'(SAMPLE_DIV - 1));

    // Count up and wrap to zero on the tick cycle.
    always_comb begin
        count_d = tick ? '0 : count_q + CW'(1);
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) count_q <= '0;
        else         count_q <= count_d;
    end

endmodule

// File: rtl/audio_track_sequencer.sv
// Chooses the music track from game state on each sample tick, steps the
// ROM read addresses and registers the selected ROM byte into the sample
// word two cycles after the tick (one cycle of ROM read latency).
module audio_track_sequencer
    import audio_seq_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int LONG_LEN   = DEF_LONG_LEN,
    parameter int SHORT_LEN  = DEF_SHORT_LEN,
    parameter int LOW_TH     = DEF_LOW_TH,
    parameter int DANGER_TH  = DEF_DANGER_TH,
    parameter int GAIN_SHIFT = 0
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [3:0]  oxygen_hi,
    input  logic [3:0]  oxygen_lo,
    input  logic        game_win,
    input  logic        game_loss,
    input  logic        audio_out_allowed,
    output logic [15:0] long_addr,
    output logic [15:0] short_addr,
    input  logic [7:0]  full_q,
    input  logic [7:0]  win_q,
    input  logic [7:0]  low_q,
    input  logic [7:0]  danger_q,
    output logic [2:0]  track,
    output logic [31:0] audio_sample,
    output logic        write_audio_out,
    output logic        won
);
    logic        tick;
    logic [6:0]  oxygen_sec;
    logic [2:0]  next_track;
    logic [2:0]  track_q, track_d;
    logic [15:0] long_q, long_d;
    logic [15:0] short_q, short_d;
    logic        won_q, won_d;
    logic        run_q;
    logic        tick_p1_q, tick_p2_q;
    logic [7:0]  sample_byte;
    logic [31:0] sample_q, sample_d;

    sample_tick_divider #(.SAMPLE_DIV(SAMPLE_DIV)) u_div (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .tick     (tick)
    );

    // BCD digits are combined without range checking; result wraps at 7 bits.
    assign oxygen_sec = 7'(oxygen_hi) * 7'd10 + 7'(oxygen_lo);
    assign next_track = select_track(won_q | game_win, game_loss, oxygen_sec,
                                     7'(LOW_TH), 7'(DANGER_TH));

    // On tick: restart addresses on a track change, otherwise advance both.
    always_comb begin
        track_d = track_q;
        long_d  = long_q;
        short_d = short_q;
        won_d   = won_q;
        if (tick) begin
            won_d = won_q | game_win;
            if (next_track != track_q) begin
                track_d = next_track;
                long_d  = '0;
                short_d = '0;
            end else begin
                long_d  = (long_q  == 16'(LONG_LEN - 1))  ? '0 : long_q  + 16'd1;
                short_d = (short_q == 16'(SHORT_LEN - 1)) ? '0 : short_q + 16'd1;
            end
        end
    end

    // ROM byte for the current track; LOSS and SILENT play silence.
    always_comb begin
        case (track_q)
            TRK_FULL:   sample_byte = full_q;
            TRK_LOW:    sample_byte = low_q;
            TRK_DANGER: sample_byte = danger_q;
            TRK_WIN:    sample_byte = win_q;
            default:    sample_byte = 8'h00;
        endcase
    end

    // Load two cycles after the tick, once the ROM shows the new address.
    assign sample_d = tick_p2_q ? (32'(sample_byte) << GAIN_SHIFT) : sample_q;

    // All state registers, cleared asynchronously.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            track_q   <= TRK_SILENT;
            long_q    <= '0;
            short_q   <= '0;
            won_q     <= 1'b0;
            run_q     <= 1'b0;
            tick_p1_q <= 1'b0;
            tick_p2_q <= 1'b0;
            sample_q  <= '0;
        end else begin
            track_q   <= track_d;
            long_q    <= long_d;
            short_q   <= short_d;
            won_q     <= won_d;
            run_q     <= 1'b1;
            tick_p1_q <= tick;
            tick_p2_q <= tick_p1_q;
            sample_q  <= sample_d;
        end
    end

    assign track           = track_q;
    assign long_addr       = long_q;
    assign short_addr      = short_q;
    assign won             = won_q;
    assign audio_sample    = sample_q;
    assign write_audio_out = audio_out_allowed & run_q;

endmodule

// File: doc/audio_track_sequencer.md
# audio_track_sequencer

Controller for the game's audio playback datapath. Decides which music track plays from the current game state (oxygen time left, win, loss), produces the sample-rate tick, and drives the read addresses of the four music ROMs. It registers the selected ROM byte into the 32-bit sample word for the Audio_Controller and gates its write strobe. It sits between the oxygen/game-state logic and the Audio_Controller and replaces ad-hoc track switching in the top level.

## Interface
Parameters:
- SAMPLE_DIV, 6250: CLOCK_50 cycles per sample tick (8 kHz).
- LONG_LEN, 64000: sample count of the full-oxygen and win tracks.
- SHORT_LEN, 32000: sample count of the low-oxygen and danger tracks.
- LOW_TH, 12: oxygen seconds below which the LOW track plays.
- DANGER_TH, 8: oxygen seconds below which the DANGER track plays.
- GAIN_SHIFT, 0: left shift applied to the sample byte in the output word.

Ports:
- CLOCK_50, in, 1: the single clock.
- resetn, in, 1: asynchronous, active-low reset.
- oxygen_hi, in, 4: BCD tens digit of oxygen seconds.
- oxygen_lo, in, 4: BCD units digit of oxygen seconds.
- game_win, in, 1: level, high when the game is won.
- game_loss, in, 1: level, high when the game is lost.
- audio_out_allowed, in, 1: output FIFO has space.
- long_addr, out, 16: address for the full and win ROMs.
- short_addr, out, 16: address for the low and danger ROMs.
- full_q, win_q, low_q, danger_q, in, 8 each: ROM data, 1-cycle registered read latency.
- track, out, 3: current track code.
- audio_sample, out, 32: sample word for both channels.
- write_audio_out, out, 1: FIFO write strobe.
- won, out, 1: sticky win flag.

## Operation
- Divider counts 0..SAMPLE_DIV-1. `tick` is high for one cycle when count = SAMPLE_DIV-1, and the counter then wraps to 0.
- oxygen_sec = oxygen_hi*10 + oxygen_lo, 7 bits unsigned. It is sampled only on tick. Digits above 9 are not checked.
- Track selection is evaluated on tick, first match wins:
  - won or game_win: WIN
  - game_loss: LOSS
  - oxygen_sec ≥ LOW_TH: FULL
  - oxygen_sec ≥ DANGER_TH: LOW
  - otherwise: DANGER
- won sets on the tick where game_win=1. It clears only on reset.
- If win and loss are both high, WIN is selected.
- On tick with next track ≠ track:
  - track ← next
  - long_addr ← 0, short_addr ← 0
- On tick with next track = track:
  - long_addr increments, wrapping LONG_LEN-1 → 0.
  - short_addr increments, wrapping SHORT_LEN-1 → 0.
- Sample mux by track:
  - FULL: full_q
  - LOW: low_q
  - DANGER: danger_q
  - WIN: win_q
  - LOSS and SILENT: 8'h00
- audio_sample = {24'b0, byte} << GAIN_SHIFT.
- write_audio_out = audio_out_allowed & run. run is a register cleared by reset and set on the first clock edge after reset deasserts. The held sample is re-written while the FIFO accepts data.

## Timing
- Reset values:
  - track = SILENT (0)
  - long_addr = 0, short_addr = 0
  - audio_sample = 0
  - won = 0
  - write_audio_out = 0
  - divider = 0
- First tick occurs SAMPLE_DIV cycles after reset release.
- Tick edge E0: track and addresses update.
- E1: ROM output reflects the new address.
- E2: audio_sample loads the muxed byte. Sample latency from tick is 2 cycles.
- audio_sample holds its value between loads.
- The mux uses the track value from E0, so a track change and its first sample (address 0) appear together at E2.
- Reset asserted mid-track clears everything immediately and asynchronously. Playback restarts at SILENT.
- Input changes between ticks are ignored until the next tick.

## Structure
- Package audio_seq_pkg holds:
  - track codes: SILENT=0, FULL=1, LOW=2, DANGER=3, WIN=4, LOSS=5
  - default LEN and threshold constants
- One sub-module: sample_tick_divider (parameter SAMPLE_DIV; ports CLOCK_50, resetn, tick).
- Selection, address counters and sample register live in audio_track_sequencer.

## Test plan
Bench uses SAMPLE_DIV=4, LONG_LEN=6, SHORT_LEN=3.
- Reset release, oxygen 2/5:
  - first tick at cycle 4, track=FULL, long_addr=0
  - audio_sample=full_q(0) 2 cycles later
  - write_audio_out follows audio_out_allowed from cycle 1
- Oxygen held at 25 for 8 ticks: long_addr sequence 0,1,2,3,4,5,0,1 (wrap); track stays FULL.
- Oxygen steps 12 → 11 → 7:
  - track FULL → LOW → DANGER, each on the next tick
  - short_addr resets to 0 at each change, then counts 0,1,2,0
- game_win=1 for one tick, then 0, with game_loss=1 after: won=1, track stays WIN, win_q is played; game_loss is ignored.
- game_loss=1, game_win=0: track=LOSS, audio_sample=0 from 2 cycles after the tick.
- resetn pulsed low mid-cycle during DANGER: all outputs 0 and track=SILENT in the same cycle, with no wait for a clock edge.
